quad_step_gen: RTL and testbench
================================

// Module: quad_step_gen
// PURPOSE
//  Quadrature front end for the wheel/position up-down counter.
//  - Synchronises and de-glitches encoder channels A and B.
//  - Decodes each legal Gray-code transition into a one-cycle step pulse (en)
//    plus a direction level (dwn); these drive the counter's en/dwn inputs.
//  - Flags illegal double-edge transitions on a sticky error output.
// PARAMETERS
//  FILT_CYC  4  consecutive cycles a synced channel must differ from its filtered value before it is accepted (1..15)
// PORTS
//  clk     in   1  system clock, all logic on rising edge
//  rst_n   in   1  reset, synchronous, active-low
//  A       in   1  encoder channel A, asynchronous to clk
//  B       in   1  encoder channel B, asynchronous to clk
//  err_clr in   1  clears err; one-cycle pulse or level
//  en      out  1  step strobe, exactly one cycle per accepted step
//  dwn     out  1  direction of last step: 1 = count down, 0 = count up
//  err     out  1  sticky illegal-transition flag
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is synchronous, active-low; rst_n sampled low at a clk edge clears everything at that edge.
//  - Reset values: en=0, dwn=0, err=0; sync flops=0; filter counters=0; filt_a/filt_b=0; state=INIT.
//  - Reset mid-operation aborts any filtering in progress. No step is emitted for the pre-reset position.
//  Synchroniser
//  - A and B each pass through a 2-flop synchroniser, giving sa and sb.
//  Filter (per channel, 4-bit counter)
//  - If sX==filt_X, the counter clears to 0.
//  - Otherwise the counter increments. When it would reach FILT_CYC, the channel qualifies: filt_X<=sX and the counter clears, both at that edge.
//  - Glitches shorter than FILT_CYC cycles never qualify.
//  FSM states
//  - INIT:
//    - Both channels are filtered as above. Qualifications load filt_X only; no en, no err.
//    - Exit to TRACK once both sa==filt_a and sb==filt_b, and both counters are 0, for FILT_CYC consecutive cycles.
//    - The INIT-to-TRACK move itself emits nothing.
//  - TRACK: decode {old filt_a,filt_b} -> {new} whenever either channel qualifies.
//    - Up sequence (dwn=0): 00->01->11->10->00.
//    - Down sequence (dwn=1): 00->10->11->01->00.
//    - Legal step: en=1 for the next cycle only, and dwn updates at the same edge.
//    - Both channels qualify on the same edge (2-bit change): illegal. filt takes the new values, en stays 0, dwn holds, err<=1.
//  Latency
//  - A pin change first captured by sync flop 1 at edge E0 shows en=1 in the cycle after edge E0+FILT_CYC+1 (TRACK, clean input).
//  Outputs
//  - en is registered and never high two consecutive cycles for one transition.
//  - Back-to-back steps need at least FILT_CYC cycles between them.
//  - dwn is registered and holds its last value when en=0.
//  err handling
//  - err is set by an illegal transition and cleared by err_clr.
//  - If set and clear land on the same edge, set wins (err=1).
//  - err has no effect on decoding; steps keep being produced.
// TESTING
//  - Reset with A=1,B=1 held, release rst_n: INIT loads 11, enters TRACK, no en pulse, err=0.
//  - FILT_CYC=4, from 00 drive 01,11,10,00, each held 10 cycles: 4 en pulses, dwn=0, each en at edge E0+5.
//  - From 00 drive 10,11,01,00: 4 en pulses, dwn=1 on each. Then reverse to 01: one pulse, dwn=0.
//  - 3-cycle glitch on A (shorter than FILT_CYC=4): no en, filt unchanged. 4-cycle pulse on A: exactly one en.
//  - From 00 switch A and B to 11 on the same cycle: err=1, en=0, dwn unchanged.
//    Then assert err_clr on the same edge as a second illegal jump: err stays 1. err_clr alone on a later cycle: err=0.
//  - Assert rst_n=0 for 1 cycle while the counter is mid-filter (count=2): all outputs 0 at the next edge, FSM in INIT, no stale en afterwards.

Source files
------------

// File: rtl/quad_step_gen.sv
// Quadrature encoder front end: synchronises and filters channels A/B, then turns each
// legal Gray-code transition into a one-cycle step strobe plus a direction level.
module quad_step_gen #(
  parameter int unsigned FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic err_clr,
  output logic en,
  output logic dwn,
  output logic err
);

  localparam logic [3:0] FiltMax = 4'(FILT_CYC);

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StTrack = 1'b1;

  // Synchroniser flops
  logic a_meta_q, a_sync_q;
  logic b_meta_q, b_sync_q;

  // Filter state
  logic [3:0] cnt_a_q, cnt_a_d;
  logic [3:0] cnt_b_q, cnt_b_d;
  logic       filt_a_q, filt_a_d;
  logic       filt_b_q, filt_b_d;
  logic       qual_a, qual_b;

  // Control state
  logic [0:0] state_q, state_d;
  logic [3:0] stab_q, stab_d;
  logic       stable;

  // Output registers
  logic en_q, en_d;
  logic dwn_q, dwn_d;
  logic err_q, err_d;

  logic [1:0] pos_q, pos_d;

  // Next position in the count-up Gray sequence 00->01->11->10->00.
  function automatic logic [1:0] up_next(input logic [1:0] p);
    logic [1:0] r;
    unique case (p)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  always_comb begin
    // A channel qualifies on the edge its counter would reach FiltMax.
    qual_a   = (a_sync_q != filt_a_q) && ((cnt_a_q + 4'd1) == FiltMax);
    qual_b   = (b_sync_q != filt_b_q) && ((cnt_b_q + 4'd1) == FiltMax);
    cnt_a_d  = ((a_sync_q == filt_a_q) || qual_a) ? 4'd0 : cnt_a_q + 4'd1;
    cnt_b_d  = ((b_sync_q == filt_b_q) || qual_b) ? 4'd0 : cnt_b_q + 4'd1;
    filt_a_d = qual_a ? a_sync_q : filt_a_q;
    filt_b_d = qual_b ? b_sync_q : filt_b_q;
  end

  assign pos_q  = {filt_a_q, filt_b_q};
  assign pos_d  = {filt_a_d, filt_b_d};
  assign stable = (a_sync_q == filt_a_q) && (b_sync_q == filt_b_q) &&
                  (cnt_a_q == 4'd0) && (cnt_b_q == 4'd0);

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    en_d    = 1'b0;
    dwn_d   = dwn_q;
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      StInit: begin
        if (!stable) begin
          stab_d = 4'd0;
        end else if ((stab_q + 4'd1) == FiltMax) begin
          stab_d  = 4'd0;
          state_d = StTrack;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      default: begin
        if (qual_a && qual_b) begin
          // Two-bit jump: position is lost, so flag it but keep tracking from here.
          err_d = 1'b1;
        end else if (qual_a || qual_b) begin
          en_d  = 1'b1;
          dwn_d = (pos_d != up_next(pos_q));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      cnt_a_q  <= 4'd0;
      cnt_b_q  <= 4'd0;
      filt_a_q <= 1'b0;
      filt_b_q <= 1'b0;
      state_q  <= StInit;
      stab_q   <= 4'd0;
      en_q     <= 1'b0;
      dwn_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_meta_q <= A;
      a_sync_q <= a_meta_q;
      b_meta_q <= B;
      b_sync_q <= b_meta_q;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      filt_a_q <= filt_a_d;
      filt_b_q <= filt_b_d;
      state_q  <= state_d;
      stab_q   <= stab_d;
      en_q     <= en_d;
      dwn_q    <= dwn_d;
      err_q    <= err_d;
    end
  end

  assign en  = en_q;
  assign dwn = dwn_q;
  assign err = err_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Scoreboard bench for quad_step_gen: each legal step driven queues its expected direction
// and strobe cycle; a negedge monitor pops and compares every en pulse.
module tb_quad_step_gen;

  localparam int unsigned FiltCyc = 4;
  localparam logic [0:0] ExpInit  = 1'b0;
  localparam logic [0:0] ExpTrack = 1'b1;

  logic clk = 1'b0;
  logic rst_n, a_in, b_in, err_clr;
  logic en, dwn, err;

  typedef struct {
    logic        dwn;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  quad_step_gen #(.FILT_CYC(FiltCyc)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a_in),
    .B       (b_in),
    .err_clr (err_clr),
    .en      (en),
    .dwn     (dwn),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new pin pair; a legal step is expected FiltCyc+2 cycles after the drive cycle.
  task automatic drive(input logic a, input logic b, input bit step, input logic exp_dwn,
                       input int hold);
    exp_t e;
    a_in = a;
    b_in = b;
    if (step) begin
      e.dwn = exp_dwn;
      e.cyc = cyc + FiltCyc + 2;
      sb_q.push_back(e);
    end
    tick(hold);
  endtask

  always @(negedge clk) begin
    if (en !== 1'b0) begin
      if (sb_q.size() == 0) begin
        check("spurious_en", 32'(en), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("step_dwn", 32'(dwn), 32'(e.dwn));
        check("step_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    a_in    = 1'b1;
    b_in    = 1'b1;
    err_clr = 1'b0;
    tick(3);
    check("rst_en", 32'(en), 32'd0);
    check("rst_dwn", 32'(dwn), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ExpInit));
    rst_n = 1'b1;
    tick(20);
    check("init_filt_11", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd3);
    check("init_track", 32'(dut.state_q), 32'(ExpTrack));
    check("init_err", 32'(err), 32'd0);

    // Up: 11->10->00, then a full up cycle from 00.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 10);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 10);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 10);
    // Down cycle from 00, then reverse to 01.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 10);
    check("dwn_after_reverse", 32'(dwn), 32'd0);

    // 3-cycle glitch on A is rejected.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10);
    check("glitch_filt", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd1);
    // 4-cycle pulse on A qualifies once; its trailing edge is a legal step back.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 12);
    check("pulse_filt", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd1);

    // 01->00 (down), then illegal 00->11.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 10);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_dwn", 32'(dwn), 32'd1);
    check("illegal_filt", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd3);
    // Second illegal jump qualifies on the same edge as err_clr: set wins.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("set_wins_err", 32'(err), 32'd1);
    check("set_wins_filt", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd0);
    tick(5);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("clr_err", 32'(err), 32'd0);
    check("clr_dwn_hold", 32'(dwn), 32'd1);

    // Reset while A is mid-filter.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4);
    check("midfilt_cnt", 32'(dut.cnt_a_q), 32'd2);
    rst_n = 1'b0;
    tick(1);
    check("midrst_en", 32'(en), 32'd0);
    check("midrst_dwn", 32'(dwn), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(ExpInit));
    check("midrst_cnt", 32'(dut.cnt_a_q), 32'd0);
    rst_n = 1'b1;
    tick(20);
    check("post_rst_track", 32'(dut.state_q), 32'(ExpTrack));
    check("post_rst_filt", 32'({dut.filt_a_q, dut.filt_b_q}), 32'd2);
    // Decoding still works after reset: 10->11 is a down step.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 12);

    check("missing_en", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
